// File: rtl/mag_comp_seq.sv
// Bit-serial magnitude comparator: scans A and B from the MSB down and reports A>B, A==B or A<B.
// Latency: WIDTH-i edges after accept (i = first differing bit) with EARLY_EXIT=1, else always WIDTH edges.
// Backpressure: none; start is ignored while busy and accepted again in IDLE or in the DONE cycle.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   start              request a comparison (captures a, b, signed_mode)
//   signed_mode        1 = two's-complement compare, 0 = unsigned
//   a, b               WIDTH-bit operands
//   busy               high while scanning
//   done               one-cycle pulse with a valid result
//   g, e, l            A>B, A==B, A<B (registered, held until the next accept)
module mag_comp_seq #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sm_q;
    logic             found_q;     // a difference has already been seen (full-scan mode)
    logic             found_gt_q;  // verdict of that first difference: 1 = A>B
    logic             busy_q;
    logic             done_q;
    logic             g_q;
    logic             e_q;
    logic             l_q;

    logic bit_diff;
    logic bit_gt;
    logic res_found;
    logic res_gt;

    always_comb begin
        bit_diff = a_q[idx_q] ^ b_q[idx_q];
        // In signed mode the MSB is the sign: a set A bit means A is negative,
        // so when the sign bits differ A>B exactly when B carries the set bit.
        if (sm_q && (idx_q == IDX_MSB)) begin
            bit_gt = b_q[idx_q];
        end else begin
            bit_gt = a_q[idx_q];
        end
        // Final verdict at idx 0 in full-scan mode: an earlier difference wins
        // over the current bit.
        res_found = found_q | bit_diff;
        res_gt    = found_q ? found_gt_q : bit_gt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= IDX_MSB;
            a_q        <= '0;
            b_q        <= '0;
            sm_q       <= 1'b0;
            found_q    <= 1'b0;
            found_gt_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            g_q        <= 1'b0;
            e_q        <= 1'b0;
            l_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q        <= a;
                        b_q        <= b;
                        sm_q       <= signed_mode;
                        idx_q      <= IDX_MSB;
                        found_q    <= 1'b0;
                        found_gt_q <= 1'b0;
                        g_q        <= 1'b0;
                        e_q        <= 1'b0;
                        l_q        <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    if ((EARLY_EXIT != 0) && bit_diff) begin
                        g_q     <= bit_gt;
                        e_q     <= 1'b0;
                        l_q     <= ~bit_gt;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (idx_q == '0) begin
                        g_q     <= res_found & res_gt;
                        e_q     <= ~res_found;
                        l_q     <= res_found & ~res_gt;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        if (!found_q && bit_diff) begin
                            found_q    <= 1'b1;
                            found_gt_q <= bit_gt;
                        end
                        idx_q <= idx_q - IW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign g    = g_q;
    assign e    = e_q;
    assign l    = l_q;

endmodule

// File: tb/tb_mag_comp_seq.sv
// Bench for mag_comp_seq: three instances (W4 early-exit, W4 full-scan, W8 early-exit).
// Expected results are queued at drive time and popped when done is seen.
// Outputs are sampled 1 ns after the rising edge.
module tb_mag_comp_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic       sm_r;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] g_v;
    logic [2:0] e_v;
    logic [2:0] l_v;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] gel;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    mag_comp_seq #(.WIDTH(4), .EARLY_EXIT(1)) u_w4e (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm_r),
        .a(a_r[3:0]), .b(b_r[3:0]), .busy(busy_v[0]), .done(done_v[0]),
        .g(g_v[0]), .e(e_v[0]), .l(l_v[0])
    );

    mag_comp_seq #(.WIDTH(4), .EARLY_EXIT(0)) u_w4f (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm_r),
        .a(a_r[3:0]), .b(b_r[3:0]), .busy(busy_v[1]), .done(done_v[1]),
        .g(g_v[1]), .e(e_v[1]), .l(l_v[1])
    );

    mag_comp_seq #(.WIDTH(8), .EARLY_EXIT(1)) u_w8e (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm_r),
        .a(a_r), .b(b_r), .busy(busy_v[2]), .done(done_v[2]),
        .g(g_v[2]), .e(e_v[2]), .l(l_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] gel(input int s);
        return {g_v[s], e_v[s], l_v[s]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Called 1 ns after the accept edge; follows the comparison to its done.
    task automatic collect(input int s, input bit tail);
        int   lat;
        int   bc;
        bit   got;
        exp_t ex;
        chk("clear_on_accept", {29'd0, gel(s)}, 32'd0);
        lat = 0;
        bc  = busy_v[s] ? 1 : 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_v[s]) got = 1'b1;
            else if (busy_v[s]) bc++;
        end
        ex = exp_q.pop_front();
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", lat, ex.lat);
        chk("busy_cycles", bc, ex.lat);
        chk("result_gel", {29'd0, gel(s)}, {29'd0, ex.gel});
        if (tail) begin
            @(posedge clk);
            #1;
            chk("done_one_cycle", {31'd0, done_v[s]}, 32'd0);
            chk("result_hold", {29'd0, gel(s)}, {29'd0, ex.gel});
        end
    endtask

    task automatic run(input int s, input logic [7:0] av, input logic [7:0] bv,
                       input logic smv, input logic [2:0] eg, input int el);
        exp_q.push_back('{gel: eg, lat: el});
        a_r        = av;
        b_r        = bv;
        sm_r       = smv;
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        collect(s, 1'b1);
    endtask

    initial begin
        bit seen;
        rst_n   = 1'b1;
        start_v = '0;
        sm_r    = 1'b0;
        a_r     = '0;
        b_r     = '0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("reset_busy", {31'd0, busy_v[s]}, 32'd0);
            chk("reset_done", {31'd0, done_v[s]}, 32'd0);
            chk("reset_gel", {29'd0, gel(s)}, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // W4 early exit, unsigned
        run(0, 8'd3,  8'd7,  1'b0, 3'b001, 2);
        run(0, 8'd14, 8'd11, 1'b0, 3'b100, 2);
        run(0, 8'd10, 8'd10, 1'b0, 3'b010, 4);
        // W4 sign-bit difference, signed then unsigned
        run(0, 8'b1000, 8'b0111, 1'b1, 3'b001, 1);
        run(0, 8'b1000, 8'b0111, 1'b0, 3'b100, 1);
        // W4 full scan
        run(1, 8'd8, 8'd9, 1'b0, 3'b001, 4);
        run(1, 8'd7, 8'd8, 1'b1, 3'b100, 4);
        run(1, 8'd5, 8'd5, 1'b1, 3'b010, 4);
        // W8 signed
        run(2, 8'hFF, 8'h01, 1'b1, 3'b001, 1);
        run(2, 8'hFE, 8'hFF, 1'b1, 3'b001, 8);

        // W8: start pulsed again during SCAN with new operands is ignored
        exp_q.push_back('{gel: 3'b100, lat: 8});
        a_r        = 8'h01;
        b_r        = 8'h00;
        sm_r       = 1'b0;
        start_v[2] = 1'b1;
        @(posedge clk);
        #1;
        a_r = 8'h00;
        b_r = 8'h00;
        fork
            begin
                @(posedge clk);
                #1;
                start_v[2] = 1'b0;
            end
        join_none
        collect(2, 1'b1);

        // Reset between edges during SCAN aborts the comparison
        a_r        = 8'h00;
        b_r        = 8'h01;
        start_v[2] = 1'b1;
        @(posedge clk);
        #1;
        start_v[2] = 1'b0;
        chk("abort_busy_before", {31'd0, busy_v[2]}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_v[2]}, 32'd0);
        chk("abort_done", {31'd0, done_v[2]}, 32'd0);
        chk("abort_gel", {29'd0, gel(2)}, 32'd0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done_v[2]) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_v[2]) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, seen}, 32'd0);
        run(2, 8'd5, 8'd5, 1'b0, 3'b010, 8);

        // Back-to-back: start held through DONE with new operands
        exp_q.push_back('{gel: 3'b001, lat: 2});
        exp_q.push_back('{gel: 3'b100, lat: 2});
        a_r        = 8'd3;
        b_r        = 8'd7;
        sm_r       = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        a_r = 8'd14;
        b_r = 8'd11;
        collect(0, 1'b0);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        chk("b2b_busy", {31'd0, busy_v[0]}, 32'd1);
        chk("b2b_done_low", {31'd0, done_v[0]}, 32'd0);
        collect(0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
